// File: rtl/triangle_channel_gen.sv
// Triangle voice with selectable resolution, optional sawtooth shape and ultrasonic mute.
// Register writes, frame-sequencer ticks and the channel timer all update on the same clock.
module triangle_channel_gen #(
   parameter int unsigned OUT_W     = 4,
   parameter bit          SAW_EN    = 1'b0,
   parameter int unsigned TIMER_MIN = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             reg_we_i,
   input  logic [1:0]       reg_addr_i,
   input  logic [7:0]       reg_data_i,
   input  logic             quarter_tick_i,
   input  logic             half_tick_i,
   input  logic             enable_i,
   output logic [OUT_W-1:0] wave_o,
   output logic             length_active_o
);

   localparam int unsigned STEP_W   = OUT_W + 1;
   localparam logic [10:0] TimerMin = 11'(TIMER_MIN);

   logic              ctrl_q, ctrl_d;
   logic [6:0]        lin_reload_q, lin_reload_d;
   logic              saw_q, saw_d;
   logic [10:0]       period_q, period_d;
   logic [10:0]       timer_q, timer_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [6:0]        lin_q, lin_d;
   logic [7:0]        len_q, len_d;
   logic              reload_q, reload_d;
   logic [OUT_W-1:0]  wave_q, wave_d;
   logic              len_active_q, len_active_d;

   logic wr0, wr1, wr2, wr3, reload_eff;

   function automatic logic [7:0] len_lut(input logic [4:0] idx);
      logic [7:0] v;
      unique case (idx)
         5'd0:  v = 8'd10;   5'd1:  v = 8'd254; 5'd2:  v = 8'd20;  5'd3:  v = 8'd2;
         5'd4:  v = 8'd40;   5'd5:  v = 8'd4;   5'd6:  v = 8'd80;  5'd7:  v = 8'd6;
         5'd8:  v = 8'd160;  5'd9:  v = 8'd8;   5'd10: v = 8'd60;  5'd11: v = 8'd10;
         5'd12: v = 8'd14;   5'd13: v = 8'd12;  5'd14: v = 8'd26;  5'd15: v = 8'd14;
         5'd16: v = 8'd12;   5'd17: v = 8'd16;  5'd18: v = 8'd24;  5'd19: v = 8'd18;
         5'd20: v = 8'd48;   5'd21: v = 8'd20;  5'd22: v = 8'd96;  5'd23: v = 8'd22;
         5'd24: v = 8'd192;  5'd25: v = 8'd24;  5'd26: v = 8'd72;  5'd27: v = 8'd26;
         5'd28: v = 8'd16;   5'd29: v = 8'd28;  5'd30: v = 8'd32;  default: v = 8'd30;
      endcase
      return v;
   endfunction

   always_comb begin
      ctrl_d       = ctrl_q;
      lin_reload_d = lin_reload_q;
      saw_d        = saw_q;
      period_d     = period_q;
      timer_d      = timer_q;
      step_d       = step_q;
      lin_d        = lin_q;
      len_d        = len_q;

      wr0 = reg_we_i && (reg_addr_i == 2'd0);
      wr1 = reg_we_i && (reg_addr_i == 2'd1);
      wr2 = reg_we_i && (reg_addr_i == 2'd2);
      wr3 = reg_we_i && (reg_addr_i == 2'd3);

      if (wr0) {ctrl_d, lin_reload_d} = reg_data_i;
      if (SAW_EN && wr1) saw_d = reg_data_i[0];
      if (wr2) period_d[7:0] = reg_data_i;
      if (wr3) period_d[10:8] = reg_data_i[2:0];

      // Short periods would produce ultrasonic output, so the step holds instead.
      if (timer_q == 11'd0) begin
         timer_d = period_q;
         if ((lin_q != 7'd0) && (len_q != 8'd0) && (period_q >= TimerMin)) begin
            step_d = step_q + STEP_W'(1);
         end
      end else begin
         timer_d = timer_q - 11'd1;
      end

      reload_eff = reload_q || wr3;
      reload_d   = reload_eff;
      if (quarter_tick_i) begin
         if (reload_eff) lin_d = lin_reload_q;
         else if (lin_q != 7'd0) lin_d = lin_q - 7'd1;
         reload_d = reload_eff && ctrl_q;
      end

      if (!enable_i) begin
         len_d = 8'd0;
      end else if (wr3) begin
         len_d = len_lut(reg_data_i[7:3]);
      end else if (half_tick_i && !ctrl_q && (len_q != 8'd0)) begin
         len_d = len_q - 8'd1;
      end

      if (SAW_EN && saw_q) wave_d = step_q[OUT_W:1];
      else if (step_q[OUT_W]) wave_d = step_q[OUT_W-1:0];
      else wave_d = ~step_q[OUT_W-1:0];

      len_active_d = (len_d != 8'd0);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ctrl_q       <= 1'b0;
         lin_reload_q <= '0;
         saw_q        <= 1'b0;
         period_q     <= '0;
         timer_q      <= '0;
         step_q       <= '0;
         lin_q        <= '0;
         len_q        <= '0;
         reload_q     <= 1'b0;
         wave_q       <= '0;
         len_active_q <= 1'b0;
      end else begin
         ctrl_q       <= ctrl_d;
         lin_reload_q <= lin_reload_d;
         saw_q        <= saw_d;
         period_q     <= period_d;
         timer_q      <= timer_d;
         step_q       <= step_d;
         lin_q        <= lin_d;
         len_q        <= len_d;
         reload_q     <= reload_d;
         wave_q       <= wave_d;
         len_active_q <= len_active_d;
      end
   end

   assign wave_o          = wave_q;
   assign length_active_o = len_active_q;

endmodule

// File: tb/tb_triangle_channel_gen.sv
// Bench for triangle_channel_gen: directed scenarios then random traffic, all outputs
// scoreboarded every clock against a behavioural model of the channel.
module tb_triangle_channel_gen;

   localparam int OUT_W = 4;
   localparam int STEPS = 2 ** (OUT_W + 1);
   localparam int HALF  = STEPS / 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             reg_we = 1'b0;
   logic [1:0]       reg_addr = '0;
   logic [7:0]       reg_data = '0;
   logic             quarter = 1'b0;
   logic             half = 1'b0;
   logic             enable = 1'b0;
   logic [OUT_W-1:0] wave;
   logic             len_active;

   int n_cmp = 0;
   int n_fail = 0;
   int exp_q[$];

   int len_table[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                         12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

   // Behavioural model state
   int m_ctrl, m_lin_rl, m_saw, m_period, m_cnt, m_step, m_lin, m_len, m_flag;

   triangle_channel_gen #(
      .OUT_W    (OUT_W),
      .SAW_EN   (1'b1),
      .TIMER_MIN(2)
   ) dut (
      .clk_i          (clk),
      .reset_i        (rst),
      .reg_we_i       (reg_we),
      .reg_addr_i     (reg_addr),
      .reg_data_i     (reg_data),
      .quarter_tick_i (quarter),
      .half_tick_i    (half),
      .enable_i       (enable),
      .wave_o         (wave),
      .length_active_o(len_active)
   );

   always #5 clk = ~clk;

   // Sample value for position s of the sequence: triangle falls 15..0 then rises 0..15.
   function automatic int shape(input int s, input int saw);
      if (saw != 0) return s / 2;
      if (s < HALF) return HALF - 1 - s;
      return s - HALF;
   endfunction

   task automatic model_clear();
      m_ctrl = 0; m_lin_rl = 0; m_saw = 0; m_period = 0; m_cnt = 0;
      m_step = 0; m_lin = 0; m_len = 0; m_flag = 0;
   endtask

   always @(posedge clk or posedge rst) begin
      int ew, flag;
      bit w3;
      if (rst) begin
         model_clear();
         if (clk) exp_q.push_back(0);
      end else begin
         ew = shape(m_step, m_saw);
         if (m_cnt == 0) begin
            m_cnt = m_period;
            if (m_lin != 0 && m_len != 0 && m_period >= 2) m_step = (m_step + 1) % STEPS;
         end else begin
            m_cnt = m_cnt - 1;
         end
         w3 = reg_we && reg_addr == 2'd3;
         flag = (m_flag != 0 || w3) ? 1 : 0;
         if (quarter) begin
            if (flag != 0) m_lin = m_lin_rl;
            else if (m_lin > 0) m_lin = m_lin - 1;
            if (m_ctrl == 0) flag = 0;
         end
         if (!enable) m_len = 0;
         else if (w3) m_len = len_table[int'(reg_data) / 8];
         else if (half && m_ctrl == 0 && m_len > 0) m_len = m_len - 1;
         m_flag = flag;
         if (reg_we) begin
            case (reg_addr)
               2'd0: begin m_ctrl = int'(reg_data) / 128; m_lin_rl = int'(reg_data) % 128; end
               2'd1: m_saw = int'(reg_data) % 2;
               2'd2: m_period = (m_period / 256) * 256 + int'(reg_data);
               default: m_period = (int'(reg_data) % 8) * 256 + m_period % 256;
            endcase
         end
         exp_q.push_back(ew * 2 + ((m_len != 0) ? 1 : 0));
      end
   end

   always @(posedge clk) begin
      int e, g;
      #1;
      g = int'(wave) * 2 + int'(len_active);
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
         n_fail = n_fail + 1;
         $display("FAIL scoreboard_empty t=%0t got wave=%0d act=%0d", $time, wave, len_active);
      end else begin
         e = exp_q.pop_front();
         if (e != g) begin
            n_fail = n_fail + 1;
            $display("FAIL sample t=%0t got wave=%0d act=%0d expected wave=%0d act=%0d",
                     $time, g / 2, g % 2, e / 2, e % 2);
         end
      end
   end

   task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit q = 0, input bit h = 0);
      reg_we = 1'b1; reg_addr = a; reg_data = d; quarter = q; half = h;
      @(negedge clk);
      reg_we = 1'b0; quarter = 1'b0; half = 1'b0;
   endtask

   task automatic tick(input bit q, input bit h);
      quarter = q; half = h;
      @(negedge clk);
      quarter = 1'b0; half = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      n_cmp = n_cmp + 1;
      if (wave !== '0 || len_active !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL async_reset got wave=%0d act=%0d expected wave=0 act=0", wave, len_active);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      idle(3);
      rst = 1'b0;
      enable = 1'b1;
      idle(2);

      // Triangle at period 10, linear reload held by ctrl
      wr(2'd0, 8'h94); wr(2'd2, 8'h0A); wr(2'd3, 8'h08);
      tick(1, 0);
      idle(360);

      // Linear counter running down to zero and freezing the wave
      wr(2'd0, 8'h03); wr(2'd3, 8'h08);
      for (int i = 0; i < 6; i++) begin tick(1, 0); idle(13); end

      // Length counter expiring and enable clearing
      wr(2'd0, 8'h7F); wr(2'd3, 8'h18, 1, 0);
      tick(0, 1); idle(3); tick(0, 1); idle(3);
      wr(2'd3, 8'h18); idle(2);
      enable = 1'b0; idle(3); enable = 1'b1;

      // Load beats half tick in the same clock
      wr(2'd3, 8'h10, 0, 1);
      for (int i = 0; i < 21; i++) tick(0, 1);
      idle(3);

      // Ultrasonic period stalls the step
      wr(2'd0, 8'h94); wr(2'd2, 8'h01); wr(2'd3, 8'h00, 1, 0);
      idle(40);

      // Sawtooth
      wr(2'd1, 8'h01); wr(2'd2, 8'h0A); wr(2'd3, 8'h08, 1, 0);
      idle(360);
      wr(2'd1, 8'h00);

      // Reset mid-cycle, then nothing moves until reprogrammed
      wr(2'd2, 8'h0A); wr(2'd3, 8'h08, 1, 0);
      idle(57);
      do_reset();
      idle(30);
      wr(2'd0, 8'h94); wr(2'd2, 8'h03); wr(2'd3, 8'h08, 1, 0);
      idle(40);

      // Random traffic
      for (int i = 0; i < 6000; i++) begin
         reg_we   = ($urandom_range(0, 11) == 0);
         reg_addr = 2'($urandom_range(0, 3));
         case (reg_addr)
            2'd0:    reg_data = 8'($urandom_range(0, 255));
            2'd1:    reg_data = 8'($urandom_range(0, 3));
            2'd2:    reg_data = 8'($urandom_range(0, 12));
            default: reg_data = {5'($urandom_range(0, 31)), 3'b000};
         endcase
         quarter = ($urandom_range(0, 5) == 0);
         half    = ($urandom_range(0, 6) == 0);
         enable  = ($urandom_range(0, 60) != 0);
         @(negedge clk);
      end
      reg_we = 1'b0; quarter = 1'b0; half = 1'b0;
      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
